// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
// Shared definitions for the pipelined priority encoder:
//   clog2()      - index width helper, usable in constant expressions
//   PRIO_FIXED   - RR_MODE value selecting highest-index-wins priority
//   PRIO_RR      - RR_MODE value selecting round-robin priority
//   multi_set()  - true when a vector has two or more bits set
// Optional feature macro used by the top level: PRIO_ENC_ONEHOT_EN.
// -----------------------------------------------------------------------------
package prio_enc_pkg;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Widest request vector the helpers below are sized for.
   localparam int MAX_WIDTH  = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Clearing the lowest set bit leaves something only if a second bit exists.
   function automatic logic multi_set(input logic [MAX_WIDTH-1:0] v);
      return (v & (v - 64'd1)) != '0;
   endfunction

endpackage

// File: rtl/prio_enc_core.sv
// -----------------------------------------------------------------------------
// prio_enc_core
// Purely combinational winner search.
//   req   [WIDTH]  request lines, bit i = request i
//   ptr   [IDXW]   round-robin start index (ignored in fixed mode)
//   mode  [1]      0 = highest index wins, 1 = first set bit at/after ptr
//   idx   [IDXW]   winning index, 0 when req is all-zero
//   none  [1]      req is all-zero
//   multi [1]      req has two or more bits set
// -----------------------------------------------------------------------------
module prio_enc_core
   import prio_enc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]        req,
   input  logic [clog2(WIDTH)-1:0] ptr,
   input  logic                    mode,
   output logic [clog2(WIDTH)-1:0] idx,
   output logic                    none,
   output logic                    multi
);

   localparam int IDXW = clog2(WIDTH);

   logic [IDXW-1:0] fixed_idx;   // highest set bit
   logic [IDXW-1:0] wrap_idx;    // lowest set bit, used when nothing sits at/after ptr
   logic [IDXW-1:0] upper_idx;   // lowest set bit at index >= ptr
   logic            upper_found;

   always_comb begin
      fixed_idx   = '0;
      wrap_idx    = '0;
      upper_idx   = '0;
      upper_found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (req[i]) fixed_idx = IDXW'(i);
      end
      // Descending scan so the last hit is the lowest qualifying index.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) wrap_idx = IDXW'(i);
         if (req[i] && (i >= int'(ptr))) begin
            upper_idx   = IDXW'(i);
            upper_found = 1'b1;
         end
      end
   end

   assign none  = ~|req;
   assign multi = multi_set(MAX_WIDTH'(req));
   assign idx   = none ? '0 :
                  (mode ? (upper_found ? upper_idx : wrap_idx) : fixed_idx);

endmodule

// File: rtl/prio_encoder_pipe.sv
// -----------------------------------------------------------------------------
// prio_encoder_pipe
// Priority encoder with a one-entry registered output stage.
//   clk        [1]      clock, rising edge
//   rst_n      [1]      synchronous active-low reset
//   req_valid  [1]      request vector present on req
//   req_ready  [1]      block accepts req this cycle
//   req        [WIDTH]  request lines
//   enc_valid  [1]      result held on enc_*
//   enc_ready  [1]      consumer takes the result this cycle
//   enc_idx    [IDXW]   winning index
//   enc_none   [1]      accepted vector was all-zero
//   enc_multi  [1]      accepted vector had two or more bits set
//   enc_onehot [WIDTH]  one-hot winner, only with PRIO_ENC_ONEHOT_EN defined
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at a rising edge. req_ready = !enc_valid || enc_ready, so a new vector
// may enter in the same cycle the held result leaves (full rate, 1-cycle
// latency); while enc_valid && !enc_ready the held result stays put.
// -----------------------------------------------------------------------------
module prio_encoder_pipe
   import prio_enc_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RR_MODE = PRIO_FIXED
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [WIDTH-1:0]        req,
   output logic                    enc_valid,
   input  logic                    enc_ready,
   output logic [clog2(WIDTH)-1:0] enc_idx,
   output logic                    enc_none,
   output logic                    enc_multi
`ifdef PRIO_ENC_ONEHOT_EN
   ,
   output logic [WIDTH-1:0]        enc_onehot
`endif
);

   localparam int   IDXW   = clog2(WIDTH);
   localparam logic RR_SEL = (RR_MODE == PRIO_RR);

   logic            in_xfer;
   logic [IDXW-1:0] core_idx;
   logic            core_none;
   logic            core_multi;

   logic            enc_valid_q, enc_valid_d;
   logic [IDXW-1:0] enc_idx_q,   enc_idx_d;
   logic            enc_none_q,  enc_none_d;
   logic            enc_multi_q, enc_multi_d;
   logic [IDXW-1:0] ptr_q,       ptr_d;

   prio_enc_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .req   (req),
      .ptr   (ptr_q),
      .mode  (RR_SEL),
      .idx   (core_idx),
      .none  (core_none),
      .multi (core_multi)
   );

   assign req_ready = !enc_valid_q || enc_ready;
   assign in_xfer   = req_valid && req_ready;

   always_comb begin
      enc_valid_d = enc_valid_q;
      enc_idx_d   = enc_idx_q;
      enc_none_d  = enc_none_q;
      enc_multi_d = enc_multi_q;
      ptr_d       = ptr_q;
      if (in_xfer) begin
         enc_valid_d = 1'b1;
         enc_idx_d   = core_idx;
         enc_none_d  = core_none;
         enc_multi_d = core_multi;
         // Empty vectors grant nothing, so the pointer does not advance.
         // Explicit wrap keeps non-power-of-two widths inside 0..WIDTH-1.
         if (!core_none) begin
            ptr_d = (core_idx == IDXW'(WIDTH - 1)) ? '0 : core_idx + 1'b1;
         end
      end else if (enc_ready) begin
         enc_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enc_valid_q <= 1'b0;
         enc_idx_q   <= '0;
         enc_none_q  <= 1'b0;
         enc_multi_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         enc_valid_q <= enc_valid_d;
         enc_idx_q   <= enc_idx_d;
         enc_none_q  <= enc_none_d;
         enc_multi_q <= enc_multi_d;
         ptr_q       <= ptr_d;
      end
   end

   assign enc_valid = enc_valid_q;
   assign enc_idx   = enc_idx_q;
   assign enc_none  = enc_none_q;
   assign enc_multi = enc_multi_q;

`ifdef PRIO_ENC_ONEHOT_EN
   logic [WIDTH-1:0] enc_onehot_q, enc_onehot_d;

   always_comb begin
      enc_onehot_d = enc_onehot_q;
      if (in_xfer) begin
         enc_onehot_d = core_none ? '0 : (WIDTH'(1) << core_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enc_onehot_q <= '0;
      end else begin
         enc_onehot_q <= enc_onehot_d;
      end
   end

   assign enc_onehot = enc_onehot_q;
`endif

endmodule
